// File: rtl/serial_pair_tx.sv
// Parallel-to-serial driver for a bit-serial two-operand comparator.
// Shifts a word pair out MSB-first, captures the verdict, then clears the comparator.
module serial_pair_tx #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a,
  output logic             b,
  output logic             sync_rst,
  input  logic [1:0]       y_in,
  output logic [1:0]       result,
  output logic             result_valid,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_a_q, sreg_a_d;
  logic [WIDTH-1:0] sreg_b_q, sreg_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             sync_rst_q, sync_rst_d;
  logic [1:0]       result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  // Shift registers hold the bits still to be sent; a_q/b_q carry the bit on the wire.
  always_comb begin
    state_d        = state_q;
    sreg_a_d       = sreg_a_q;
    sreg_b_d       = sreg_b_q;
    cnt_d          = cnt_q;
    gcnt_d         = gcnt_q;
    a_d            = a_q;
    b_d            = b_q;
    sync_rst_d     = sync_rst_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    busy_d         = busy_q;
    in_ready_d     = in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_SHIFT;
          a_d        = in_a[WIDTH-1];
          b_d        = in_b[WIDTH-1];
          sreg_a_d   = {in_a[WIDTH-2:0], 1'b0};
          sreg_b_d   = {in_b[WIDTH-2:0], 1'b0};
          cnt_d      = CNT_LAST;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          a_d      = sreg_a_q[WIDTH-1];
          b_d      = sreg_b_q[WIDTH-1];
          sreg_a_d = {sreg_a_q[WIDTH-2:0], 1'b0};
          sreg_b_d = {sreg_b_q[WIDTH-2:0], 1'b0};
          cnt_d    = cnt_q - CW'(1);
        end
      end
      ST_CAPTURE: begin
        result_d       = y_in;
        result_valid_d = 1'b1;
        if (GAP > 0) begin
          state_d    = ST_GAP;
          sync_rst_d = 1'b1;
          gcnt_d     = GAP_LOAD;
        end else begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) begin
          state_d    = ST_IDLE;
          sync_rst_d = 1'b0;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        a_d        = 1'b0;
        b_d        = 1'b0;
        sync_rst_d = 1'b0;
        busy_d     = 1'b0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sreg_a_q       <= '0;
      sreg_b_q       <= '0;
      cnt_q          <= '0;
      gcnt_q         <= '0;
      a_q            <= 1'b0;
      b_q            <= 1'b0;
      sync_rst_q     <= 1'b0;
      result_q       <= 2'b00;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      sreg_a_q       <= sreg_a_d;
      sreg_b_q       <= sreg_b_d;
      cnt_q          <= cnt_d;
      gcnt_q         <= gcnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      sync_rst_q     <= sync_rst_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign sync_rst     = sync_rst_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign in_ready     = in_ready_q;

endmodule

// File: tb/tb_serial_pair_tx.sv
// Directed bench for serial_pair_tx: GAP=2 instance with a behavioural comparator,
// plus a GAP=0 instance fed a fixed verdict.
module tb_serial_pair_tx;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic v, rdy, sa, sb, srst, rv, bsy;
  logic [W-1:0] ia, ib;
  logic [1:0] y, res;
  logic v0, rdy0, sa0, sb0, srst0, rv0, bsy0;
  logic [W-1:0] ia0, ib0;
  logic [1:0] y0, res0;
  logic [1:0] cmp;

  int checks = 0;
  int errors = 0;

  serial_pair_tx #(.WIDTH(W), .GAP(2)) dut (
    .clk(clk), .rst(rst), .in_valid(v), .in_ready(rdy), .in_a(ia), .in_b(ib),
    .a(sa), .b(sb), .sync_rst(srst), .y_in(y), .result(res),
    .result_valid(rv), .busy(bsy)
  );

  serial_pair_tx #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_a(ia0), .in_b(ib0),
    .a(sa0), .b(sb0), .sync_rst(srst0), .y_in(y0), .result(res0),
    .result_valid(rv0), .busy(bsy0)
  );

  // MSB-first comparator: first differing bit decides, 10 = a>b, 01 = a<b.
  always @(posedge clk or posedge rst) begin
    if (rst) cmp <= 2'b00;
    else if (srst) cmp <= 2'b00;
    else if (cmp == 2'b00 && sa !== sb) cmp <= {sa, sb};
  end
  assign y  = cmp;
  assign y0 = 2'b01;

  task automatic test_reset();
    rst = 1'b1; v = 1'b0; v0 = 1'b0; ia = '0; ib = '0; ia0 = '0; ib0 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sa, sb, srst, res, rv, bsy} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000000", {sa, sb, srst, res, rv, bsy});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy, bsy, rdy0, bsy0} !== 4'b1010) begin
      errors++; $display("FAIL reset_ready got %b exp 1010", {rdy, bsy, rdy0, bsy0});
    end
  endtask

  task automatic test_serialize();
    logic [W-1:0] ga, gb;
    bit rdy_bad;
    rdy_bad = 1'b0;
    v = 1'b1; ia = 32'hCA47FDEA; ib = 32'h1964CBE5;
    @(negedge clk);
    v = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      ga[k] = sa; gb[k] = sb;
      if (rdy !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (ga !== 32'hCA47FDEA) begin errors++; $display("FAIL ser_a got %h exp CA47FDEA", ga); end
    checks++;
    if (gb !== 32'h1964CBE5) begin errors++; $display("FAIL ser_b got %h exp 1964CBE5", gb); end
    checks++;
    if (rdy_bad) begin errors++; $display("FAIL ser_ready got 1 during shift exp 0"); end
    checks++;
    if ({sa, sb, rv, srst, bsy} !== 5'b00001) begin
      errors++; $display("FAIL ser_capture got %b exp 00001", {sa, sb, rv, srst, bsy});
    end
    @(negedge clk);
    checks++;
    if ({rv, res, srst} !== 4'b1101) begin
      errors++; $display("FAIL ser_result got %b exp 1101", {rv, res, srst});
    end
    @(negedge clk);
    checks++;
    if ({rv, res, srst} !== 4'b0101) begin
      errors++; $display("FAIL ser_hold got %b exp 0101", {rv, res, srst});
    end
    @(negedge clk);
    checks++;
    if ({srst, rdy, bsy} !== 3'b010) begin
      errors++; $display("FAIL ser_idle got %b exp 010", {srst, rdy, bsy});
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1a, w1b, w2a, w2b;
    logic [3:0] spat;
    int scnt;
    logic [1:0] r1, r2;
    logic rv1, rv2, rdy36;
    scnt = 0; spat = '0; r1 = '0; r2 = '0; rv1 = 0; rv2 = 0; rdy36 = 0;
    v = 1'b1; ia = 32'hB4B735C1; ib = 32'h27E88251;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      if (c == 1) begin ia = 32'h23560D0F; ib = 32'hA8A8DE49; end
      if (c <= 32) begin w1a[32 - c] = sa; w1b[32 - c] = sb; end
      if (c >= 37 && c <= 68) begin w2a[68 - c] = sa; w2b[68 - c] = sb; end
      if (c <= 36 && srst === 1'b1) scnt++;
      if (c >= 33 && c <= 36) spat[36 - c] = srst;
      if (c == 34) begin r1 = res; rv1 = rv; end
      if (c == 36) rdy36 = rdy;
      if (c == 37) v = 1'b0;
      if (c == 70) begin r2 = res; rv2 = rv; end
    end
    checks++;
    if ({w1a, w1b} !== {32'hB4B735C1, 32'h27E88251}) begin
      errors++; $display("FAIL b2b_pair1 got %h %h exp B4B735C1 27E88251", w1a, w1b);
    end
    checks++;
    if ({w2a, w2b} !== {32'h23560D0F, 32'hA8A8DE49}) begin
      errors++; $display("FAIL b2b_pair2 got %h %h exp 23560D0F A8A8DE49", w2a, w2b);
    end
    checks++;
    if (scnt != 2 || spat !== 4'b0110) begin
      errors++; $display("FAIL b2b_sync got count %0d pattern %b exp 2 0110", scnt, spat);
    end
    checks++;
    if (rdy36 !== 1'b1) begin errors++; $display("FAIL b2b_ready36 got %b exp 1", rdy36); end
    checks++;
    if ({rv1, r1, rv2, r2} !== 6'b110101) begin
      errors++; $display("FAIL b2b_results got %b exp 110101", {rv1, r1, rv2, r2});
    end
  endtask

  task automatic test_ignore_valid();
    logic [W-1:0] ga, gb;
    bit rdy_bad;
    rdy_bad = 1'b0;
    v = 1'b1; ia = 32'h0F0F00FF; ib = 32'h0F0F0100;
    @(negedge clk);
    for (int k = W - 1; k >= 0; k--) begin
      ga[k] = sa; gb[k] = sb;
      if (rdy !== 1'b0) rdy_bad = 1'b1;
      v  = (k % 2 == 1);
      ia = 32'hFFFF0000 ^ 32'(k);
      ib = 32'h12345678 + 32'(k);
      @(negedge clk);
    end
    checks++;
    if ({ga, gb} !== {32'h0F0F00FF, 32'h0F0F0100}) begin
      errors++; $display("FAIL ign_stream got %h %h exp 0F0F00FF 0F0F0100", ga, gb);
    end
    checks++;
    if (rdy_bad) begin errors++; $display("FAIL ign_ready got 1 during shift exp 0"); end
    @(negedge clk);
    checks++;
    if ({rv, res} !== 3'b101) begin errors++; $display("FAIL ign_result got %b exp 101", {rv, res}); end
    repeat (2) @(negedge clk);
    checks++;
    if ({bsy, rdy} !== 2'b01) begin errors++; $display("FAIL ign_idle got %b exp 01", {bsy, rdy}); end
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] pa, pb, ga, gb;
    int rvcnt;
    rvcnt = 0;
    pa = 32'hCA47FDEA; pb = 32'h1964CBE5;
    v = 1'b1; ia = pa; ib = pb;
    @(negedge clk);
    v = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if ({sa, sb} !== {pa[15], pb[15]}) begin
      errors++; $display("FAIL mid_bit15 got %b exp %b", {sa, sb}, {pa[15], pb[15]});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sa, sb, bsy} !== 3'b000) begin
      errors++; $display("FAIL mid_reset got %b exp 000", {sa, sb, bsy});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rv === 1'b1) rvcnt++;
    end
    checks++;
    if (rvcnt != 0 || res !== 2'b00) begin
      errors++; $display("FAIL mid_noresult got pulses %0d result %b exp 0 00", rvcnt, res);
    end
    v = 1'b1; ia = 32'hB4B735C1; ib = 32'h27E88251;
    @(negedge clk);
    v = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      ga[k] = sa; gb[k] = sb;
      @(negedge clk);
    end
    checks++;
    if ({ga, gb} !== {32'hB4B735C1, 32'h27E88251}) begin
      errors++; $display("FAIL mid_newpair got %h %h exp B4B735C1 27E88251", ga, gb);
    end
    @(negedge clk);
    checks++;
    if ({rv, res} !== 3'b110) begin errors++; $display("FAIL mid_result got %b exp 110", {rv, res}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_gap0();
    logic [W-1:0] w1a, w1b, w2a, w2b;
    bit sync_seen;
    logic [3:0] at34;
    logic rdy33;
    sync_seen = 1'b0; at34 = '0; rdy33 = 1'b1;
    v0 = 1'b1; ia0 = 32'hB4B735C1; ib0 = 32'h27E88251;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) begin ia0 = 32'h23560D0F; ib0 = 32'hA8A8DE49; end
      if (srst0 !== 1'b0) sync_seen = 1'b1;
      if (c <= 32) begin w1a[32 - c] = sa0; w1b[32 - c] = sb0; end
      if (c >= 35 && c <= 66) begin w2a[66 - c] = sa0; w2b[66 - c] = sb0; end
      if (c == 33) rdy33 = rdy0;
      if (c == 34) at34 = {rv0, res0, rdy0};
      if (c == 35) v0 = 1'b0;
    end
    checks++;
    if (sync_seen) begin errors++; $display("FAIL gap0_sync got 1 exp never"); end
    checks++;
    if ({rdy33, at34} !== 5'b01011) begin
      errors++; $display("FAIL gap0_handover got %b exp 01011", {rdy33, at34});
    end
    checks++;
    if ({w1a, w1b} !== {32'hB4B735C1, 32'h27E88251}) begin
      errors++; $display("FAIL gap0_pair1 got %h %h exp B4B735C1 27E88251", w1a, w1b);
    end
    checks++;
    if ({w2a, w2b} !== {32'h23560D0F, 32'hA8A8DE49}) begin
      errors++; $display("FAIL gap0_pair2 got %h %h exp 23560D0F A8A8DE49", w2a, w2b);
    end
  endtask

  initial begin
    test_reset();
    test_serialize();
    test_back_to_back();
    test_ignore_valid();
    test_reset_mid_shift();
    test_gap0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
